// File: rtl/rgb_frame_reader_if.sv
// Pixel-path bundle between the sync generator / frame writer and the frame-buffer reader.
// The master side drives timing strobes and the write port. The slave side returns the pixel stream.
interface rgb_frame_reader_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8
);
    logic                  video_on;
    logic                  frame_start;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rgb_data;
    logic                  rgb_valid;
    logic                  frame_done;

    modport master (
        output video_on, frame_start, wr_en, wr_addr, wr_data,
        input  rgb_data, rgb_valid, frame_done
    );

    modport slave (
        input  video_on, frame_start, wr_en, wr_addr, wr_data,
        output rgb_data, rgb_valid, frame_done
    );
endinterface

// File: rtl/rgb_frame_reader.sv
// Frame-buffer reader: replicates a low-res frame by 2^SCALE_SHIFT and streams it with a fixed 2-cycle latency.
// Define TEST_PATTERN_EN to add a test_mode_i input that substitutes colour bars for memory data.
module rgb_frame_reader #(
    parameter int    DATA_WIDTH  = 8,
    parameter int    H_ACTIVE    = 640,
    parameter int    V_ACTIVE    = 480,
    parameter int    SCALE_SHIFT = 0,
    parameter int    ADDR_WIDTH  = 19,
    parameter string INIT_FILE   = "rgb_bits_output.txt"
) (
    input  logic               clk,
    input  logic               rst,
`ifdef TEST_PATTERN_EN
    input  logic               test_mode_i,
`endif
    rgb_frame_reader_if.slave  bus
);
    localparam int LOW_W      = H_ACTIVE >> SCALE_SHIFT;
    localparam int LOW_H      = V_ACTIVE >> SCALE_SHIFT;
    localparam int DEPTH      = LOW_W * LOW_H;
    localparam int MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW         = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW         = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int SCALE_MASK = (1 << SCALE_SHIFT) - 1;

    logic [XW-1:0]         xCnt_q, xCnt_d;
    logic [YW-1:0]         yCnt_q, yCnt_d;
    logic [ADDR_WIDTH-1:0] rowBase_q, rowBase_d;
    logic [YW-1:0]         yInc;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic                  advance;
    logic                  lastPix;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] memRd_q;
    logic                  v1_q;
    logic                  last1_q;
    logic [DATA_WIDTH-1:0] pixSel;
    logic [DATA_WIDTH-1:0] rgbData_q;
    logic                  rgbValid_q;
    logic                  frameDone_q;

    assign advance = bus.video_on & ~bus.frame_start;
    assign lastPix = advance && (xCnt_q == XW'(H_ACTIVE - 1)) && (yCnt_q == YW'(V_ACTIVE - 1));
    assign yInc    = yCnt_q + YW'(1);
    assign rdAddr  = rowBase_q + ADDR_WIDTH'(xCnt_q >> SCALE_SHIFT);

    // Row base steps by one low-res line each time y enters a new replicated block, avoiding a multiplier.
    always_comb begin
        xCnt_d    = xCnt_q;
        yCnt_d    = yCnt_q;
        rowBase_d = rowBase_q;
        if (bus.frame_start) begin
            xCnt_d    = '0;
            yCnt_d    = '0;
            rowBase_d = '0;
        end else if (bus.video_on) begin
            if (xCnt_q == XW'(H_ACTIVE - 1)) begin
                xCnt_d = '0;
                if (yCnt_q == YW'(V_ACTIVE - 1)) begin
                    yCnt_d    = '0;
                    rowBase_d = '0;
                end else begin
                    yCnt_d = yInc;
                    if ((yInc & YW'(SCALE_MASK)) == '0) begin
                        rowBase_d = rowBase_q + ADDR_WIDTH'(LOW_W);
                    end
                end
            end else begin
                xCnt_d = xCnt_q + XW'(1);
            end
        end
    end

`ifdef TEST_PATTERN_EN
    localparam int B_W = DATA_WIDTH / 3;
    localparam int G_W = (DATA_WIDTH - B_W) / 2;
    localparam int R_W = DATA_WIDTH - B_W - G_W;

    logic [XW-1:0] x1_q;
    logic [2:0]    bar;

    assign bar = 3'((32'(x1_q) * 8) / H_ACTIVE);

    always_comb begin
        pixSel = memRd_q;
        if (test_mode_i) begin
            pixSel = {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}};
        end
    end
`else
    always_comb begin
        pixSel = memRd_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            xCnt_q      <= '0;
            yCnt_q      <= '0;
            rowBase_q   <= '0;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            rgbData_q   <= '0;
            rgbValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
`ifdef TEST_PATTERN_EN
            x1_q        <= '0;
`endif
        end else begin
            xCnt_q      <= xCnt_d;
            yCnt_q      <= yCnt_d;
            rowBase_q   <= rowBase_d;
            v1_q        <= advance;
            last1_q     <= lastPix;
            rgbData_q   <= v1_q ? pixSel : '0;
            rgbValid_q  <= v1_q;
            frameDone_q <= last1_q;
`ifdef TEST_PATTERN_EN
            x1_q        <= xCnt_q;
`endif
        end
    end

    // Storage is deliberately outside reset; a same-edge write lands after the read samples the old word.
    always_ff @(posedge clk) begin
        memRd_q <= mem[rdAddr[MEM_AW-1:0]];
        if (bus.wr_en && (32'(bus.wr_addr) < DEPTH)) begin
            mem[bus.wr_addr[MEM_AW-1:0]] <= bus.wr_data;
        end
    end

    assign bus.rgb_data   = rgbData_q;
    assign bus.rgb_valid  = rgbValid_q;
    assign bus.frame_done = frameDone_q;
endmodule
